aludec_pipe: RTL and testbench

Parametrised ALU control decoder with a configurable-depth control pipeline, stall/flush support and multi-cycle MUL occupancy. It decodes `aluop`/`funct3`/`funct7` combinationally in the fetch/decode boundary. It carries the ALU control code, a valid bit and an illegal flag through `STAGES` registers to the execute stage. It also holds a MUL in execute for `MUL_LAT` cycles by raising `busy` to the hazard logic.

---
 rtl/aludec_pipe.sv | 168 ++++++++++++++++
 tb/tb_aludec_pipe.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/aludec_pipe.sv
// aludec_pipe: ALU control decoder feeding a STAGES-deep control pipeline.
//
// Decodes aluop/funct3/funct7 combinationally, then carries {code, valid,
// illegal} through STAGES registers to the execute-stage outputs. When
// built with ALUDEC_MUL_EN, a MUL is held in execute for MUL_LAT cycles by a
// 4-bit down-counter whose non-zero state drives busy. Without the macro
// the MUL encoding decodes as illegal and busy is tied low.
//
// Parameters:
//   STAGES  : register stages between decode and *_e outputs (1..4)
//   CW      : ALU control code width (>= 4)
//   MUL_LAT : execute cycles occupied by a MUL (1..15)
//
// Ports:
//   clk          : clock, rising edge
//   reset        : synchronous active-high reset
//   valid_in     : decode inputs carry a real instruction
//   stall_in     : external freeze of all stages
//   flush        : kill all in-flight entries (wins over stall and busy)
//   aluop        : 00 ld/st add, 01 branch sub, 10 R-type, 11 I-type
//   funct3       : instruction funct3
//   funct7       : instruction funct7
//   alucontrol_e : control code at execute
//   valid_e      : execute entry is valid
//   illegal_e    : valid entry had an undecodable encoding
//   busy         : execute is holding a multi-cycle op
//
// Configuration macro: ALUDEC_MUL_EN
module aludec_pipe #(
  parameter int STAGES  = 2,
  parameter int CW      = 4,
  parameter int MUL_LAT = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_in,
  input  logic          stall_in,
  input  logic          flush,
  input  logic [1:0]    aluop,
  input  logic [2:0]    funct3,
  input  logic [6:0]    funct7,
  output logic [CW-1:0] alucontrol_e,
  output logic          valid_e,
  output logic          illegal_e,
  output logic          busy
);

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("aludec_pipe: STAGES out of range 1..4");
  end
  if (CW < 4) begin : g_bad_cw
    $error("aludec_pipe: CW must be >= 4");
  end
  if (MUL_LAT < 1 || MUL_LAT > 15) begin : g_bad_lat
    $error("aludec_pipe: MUL_LAT out of range 1..15");
  end

  localparam logic [CW-1:0] C_AND = CW'(4'b0000);
  localparam logic [CW-1:0] C_OR  = CW'(4'b0001);
  localparam logic [CW-1:0] C_ADD = CW'(4'b0010);
  localparam logic [CW-1:0] C_SUB = CW'(4'b0110);
  localparam logic [CW-1:0] C_SLT = CW'(4'b0111);

  logic [CW-1:0] dec_code;
  logic          dec_ill;
  logic          advance;

  logic [CW-1:0] code_q  [STAGES];
  logic          valid_q [STAGES];
  logic          ill_q   [STAGES];

  // What each stage would load on advance: stage 0 takes the decode result.
  logic [CW-1:0] src_code  [STAGES];
  logic          src_valid [STAGES];
  logic          src_ill   [STAGES];

  always_comb begin
    dec_code = C_ADD;
    dec_ill  = 1'b0;
    if (valid_in) begin
      case (aluop)
        2'b00: dec_code = C_ADD;
        2'b01: dec_code = C_SUB;
        2'b10: begin
          case ({funct7, funct3})
            10'b0000000_000: dec_code = C_ADD;
            10'b0100000_000: dec_code = C_SUB;
`ifdef ALUDEC_MUL_EN
            10'b0000001_000: dec_code = CW'(4'b0011);
`endif
            10'b0000000_111: dec_code = C_AND;
            10'b0000000_110: dec_code = C_OR;
            10'b0000000_010: dec_code = C_SLT;
            default:         dec_ill  = 1'b1;
          endcase
        end
        default: begin
          case (funct3)
            3'b000:  dec_code = C_ADD;
            3'b111:  dec_code = C_AND;
            3'b110:  dec_code = C_OR;
            3'b010:  dec_code = C_SLT;
            default: dec_ill  = 1'b1;
          endcase
        end
      endcase
    end
  end

  always_comb begin
    src_code[0]  = dec_code;
    src_valid[0] = valid_in;
    src_ill[0]   = dec_ill;
    for (int i = 1; i < STAGES; i++) begin
      src_code[i]  = code_q[i-1];
      src_valid[i] = valid_q[i-1];
      src_ill[i]   = ill_q[i-1];
    end
  end

  assign advance = !stall_in && !busy;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < STAGES; i++) begin
        code_q[i]  <= C_ADD;
        valid_q[i] <= 1'b0;
        ill_q[i]   <= 1'b0;
      end
    end else if (advance) begin
      for (int i = 0; i < STAGES; i++) begin
        code_q[i]  <= src_code[i];
        valid_q[i] <= src_valid[i];
        ill_q[i]   <= src_ill[i];
      end
    end
  end

  assign alucontrol_e = code_q[STAGES-1];
  assign valid_e      = valid_q[STAGES-1];
  assign illegal_e    = ill_q[STAGES-1];

`ifdef ALUDEC_MUL_EN
  logic [3:0] cnt;
  logic       mul_arrive;

  // The MUL code is only ever produced by a legal MUL decode.
  assign mul_arrive = src_valid[STAGES-1] && !src_ill[STAGES-1] &&
                      (src_code[STAGES-1] == CW'(4'b0011));

  // The first execute cycle is the load edge itself, so MUL_LAT-1 more
  // cycles of hold are counted.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      cnt <= 4'd0;
    end else if (advance && mul_arrive) begin
      cnt <= 4'(MUL_LAT - 1);
    end else if (cnt != 4'd0 && !stall_in) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign busy = (cnt != 4'd0);
`else
  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_aludec_pipe.sv
module tb_aludec_pipe;

  logic       clk = 1'b0;
  logic       reset, valid_in, stall_in, flush;
  logic [1:0] aluop;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [3:0] alucontrol_e;
  logic       valid_e, illegal_e, busy;

  int checks = 0;
  int errors = 0;

  aludec_pipe #(.STAGES(2), .CW(4), .MUL_LAT(3)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .stall_in(stall_in),
    .flush(flush), .aluop(aluop), .funct3(funct3), .funct7(funct7),
    .alucontrol_e(alucontrol_e), .valid_e(valid_e), .illegal_e(illegal_e),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // {valid_in, aluop, funct7, funct3}
  logic [12:0] vin [15] = '{
    13'b1_10_0000000_000,  // R ADD
    13'b1_10_0100000_000,  // R SUB
    13'b1_10_0000000_111,  // R AND
    13'b1_10_0000000_110,  // R OR
    13'b1_10_0000000_010,  // R SLT
    13'b1_11_0100000_000,  // I ADD (funct7 ignored)
    13'b1_11_0000000_111,  // I AND
    13'b1_11_1111111_110,  // I OR
    13'b1_11_0000000_010,  // I SLT
    13'b1_10_1111111_000,  // R bad funct7
    13'b1_11_0000000_001,  // I bad funct3
    13'b1_00_1111111_111,  // ld/st ADD
    13'b1_01_0000000_000,  // branch SUB
    13'b0_10_1111111_000,  // bubble over a bad encoding
    13'b1_10_0000000_011   // R unsupported funct3
  };
  // {code, valid, illegal}
  logic [5:0] vexp [15] = '{
    6'b0010_1_0, 6'b0110_1_0, 6'b0000_1_0, 6'b0001_1_0, 6'b0111_1_0,
    6'b0010_1_0, 6'b0000_1_0, 6'b0001_1_0, 6'b0111_1_0,
    6'b0010_1_1, 6'b0010_1_1, 6'b0010_1_0, 6'b0110_1_0,
    6'b0010_0_0, 6'b0010_1_1
  };

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic [12:0] v);
    {valid_in, aluop, funct7, funct3} = v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_e(input string tag, input logic [3:0] code, input logic v,
                       input logic il, input logic b);
    chk({tag, ".code"}, 32'(alucontrol_e), 32'(code));
    chk({tag, ".valid"}, 32'(valid_e), 32'(v));
    chk({tag, ".illegal"}, 32'(illegal_e), 32'(il));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
  endtask

  localparam logic [12:0] BUB  = 13'b0_00_0000000_000;
  localparam logic [12:0] MUL  = 13'b1_10_0000001_000;
  localparam logic [12:0] ADD  = 13'b1_10_0000000_000;
  localparam logic [12:0] SUB  = 13'b1_10_0100000_000;
  localparam logic [12:0] AND_ = 13'b1_10_0000000_111;
  localparam logic [12:0] OR_  = 13'b1_10_0000000_110;
  localparam logic [12:0] SLT  = 13'b1_10_0000000_010;
  localparam logic [12:0] BAD  = 13'b1_10_1111111_000;

  initial begin
    reset = 1'b1; stall_in = 1'b0; flush = 1'b0; drive(BUB);
    tick(); tick();
    chk_e("reset", 4'b0010, 1'b0, 1'b0, 1'b0);

    // Two-cycle latency
    reset = 1'b0; drive(SUB);
    tick();
    chk("lat1.valid", 32'(valid_e), 32'd0);
    drive(BUB);
    tick();
    chk_e("lat2", 4'b0110, 1'b1, 1'b0, 1'b0);
    tick();
    chk_e("lat3", 4'b0010, 1'b0, 1'b0, 1'b0);

    // Back-to-back sweep, one per cycle
    for (int i = 0; i < 15; i++) begin
      drive(vin[i]);
      tick();
      if (i > 0) chk_e($sformatf("sweep%0d", i - 1), vexp[i-1][5:2], vexp[i-1][1], vexp[i-1][0], 1'b0);
    end
    drive(BUB);
    tick();
    chk_e("sweep14", vexp[14][5:2], vexp[14][1], vexp[14][0], 1'b0);
    tick();

    // Stall freezes everything; inputs ignored while stalled
    drive(AND_); tick();
    drive(OR_);  tick();
    chk_e("stl0", 4'b0000, 1'b1, 1'b0, 1'b0);
    stall_in = 1'b1; drive(SLT);
    tick(); chk_e("stl1", 4'b0000, 1'b1, 1'b0, 1'b0);
    tick(); chk_e("stl2", 4'b0000, 1'b1, 1'b0, 1'b0);
    stall_in = 1'b0;
    tick(); chk_e("stl3", 4'b0001, 1'b1, 1'b0, 1'b0);
    drive(BUB);
    tick(); chk_e("stl4", 4'b0111, 1'b1, 1'b0, 1'b0);
    tick();

    // Flush with stall asserted: flush wins, no stale entries on refill
    drive(BAD); tick();
    drive(OR_); tick();
    chk_e("fl0", 4'b0010, 1'b1, 1'b1, 1'b0);
    flush = 1'b1; stall_in = 1'b1; drive(SLT);
    tick(); chk_e("fl1", 4'b0010, 1'b0, 1'b0, 1'b0);
    flush = 1'b0; stall_in = 1'b0; drive(SUB);
    tick(); chk_e("fl2", 4'b0010, 1'b0, 1'b0, 1'b0);
    drive(BUB);
    tick(); chk_e("fl3", 4'b0110, 1'b1, 1'b0, 1'b0);
    tick();

`ifdef ALUDEC_MUL_EN
    // MUL then ADD: MUL on *_e three cycles, busy on the first two
    drive(MUL); tick();
    drive(ADD); tick();
    chk_e("mul1", 4'b0011, 1'b1, 1'b0, 1'b1);
    tick(); chk_e("mul2", 4'b0011, 1'b1, 1'b0, 1'b1);
    tick(); chk_e("mul3", 4'b0011, 1'b1, 1'b0, 1'b0);
    drive(BUB);
    tick(); chk_e("mul4", 4'b0010, 1'b1, 1'b0, 1'b0);
    tick(); chk_e("mul5", 4'b0010, 1'b0, 1'b0, 1'b0);

    // Stall while cnt=2 pauses the count
    drive(MUL); tick();
    drive(BUB); tick();
    chk_e("ms0", 4'b0011, 1'b1, 1'b0, 1'b1);
    stall_in = 1'b1;
    tick(); chk_e("ms1", 4'b0011, 1'b1, 1'b0, 1'b1);
    tick(); chk_e("ms2", 4'b0011, 1'b1, 1'b0, 1'b1);
    stall_in = 1'b0;
    tick(); chk_e("ms3", 4'b0011, 1'b1, 1'b0, 1'b1);
    tick(); chk_e("ms4", 4'b0011, 1'b1, 1'b0, 1'b0);
    tick(); chk_e("ms5", 4'b0010, 1'b0, 1'b0, 1'b0);

    // Flush during busy
    drive(MUL); tick();
    drive(ADD); tick();
    chk_e("mf0", 4'b0011, 1'b1, 1'b0, 1'b1);
    flush = 1'b1;
    tick(); chk_e("mf1", 4'b0010, 1'b0, 1'b0, 1'b0);
    flush = 1'b0; drive(OR_);
    tick(); chk_e("mf2", 4'b0010, 1'b0, 1'b0, 1'b0);
    drive(BUB);
    tick(); chk_e("mf3", 4'b0001, 1'b1, 1'b0, 1'b0);

    // Flush on the edge the MUL would arrive: counter stays 0
    drive(MUL); tick();
    drive(BUB); flush = 1'b1;
    tick(); chk_e("mfa1", 4'b0010, 1'b0, 1'b0, 1'b0);
    flush = 1'b0;
    tick(); chk_e("mfa2", 4'b0010, 1'b0, 1'b0, 1'b0);

    // Reset mid-MUL aborts it
    drive(MUL); tick();
    drive(BUB); tick();
    chk("mr0.busy", 32'(busy), 32'd1);
    reset = 1'b1;
    tick(); chk_e("mr1", 4'b0010, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    tick(); chk_e("mr2", 4'b0010, 1'b0, 1'b0, 1'b0);
`else
    // MUL encoding is illegal and never raises busy
    drive(MUL); tick();
    drive(ADD); tick();
    chk_e("nomul1", 4'b0010, 1'b1, 1'b1, 1'b0);
    drive(BUB);
    tick(); chk_e("nomul2", 4'b0010, 1'b1, 1'b0, 1'b0);
    tick(); chk_e("nomul3", 4'b0010, 1'b0, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
